mips_harvard_bus_bridge: RTL and testbench

MIPS_HARVARD_BUS_BRIDGE -- requirements
Module: mips_harvard_bus_bridge

---
 rtl/mips_bus_pkg.sv | 17 +
 rtl/mips_bus_arbiter.sv | 61 ++++++
 rtl/mips_harvard_bus_bridge.sv | 140 ++++++++++++++
 tb/tb_mips_harvard_bus_bridge.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared state encoding and default widths for the Harvard bus bridge
package mips_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } bridge_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - requester arbiter; rotating priority when MIPS_BRIDGE_ROUND_ROBIN_EN is defined
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int IDX_W   = idx_width(N_PORTS)
) (
`ifdef MIPS_BRIDGE_ROUND_ROBIN_EN
    input  logic               clk,
    input  logic               reset,
    input  logic               accept,
`endif
    input  logic [N_PORTS-1:0] req,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

`ifdef MIPS_BRIDGE_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last;
    int               dist;
    int               best_dist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= '0;
        end else if (accept) begin
            last <= grant_idx;
        end
    end

    // Smallest distance past the last granted port wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        dist      = 0;
        best_dist = N_PORTS;
        for (int j = 0; j < N_PORTS; j++) begin
            dist = (j + N_PORTS - 1 - int'(last)) % N_PORTS;
            if (req[j] && (dist < best_dist)) begin
                best_dist = dist;
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/mips_harvard_bus_bridge.sv
// rtl/mips_harvard_bus_bridge.sv - multi-requester to single Avalon-style master bridge (MIPS_BRIDGE_ROUND_ROBIN_EN selects rotating grant)
module mips_harvard_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_PORTS = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]    req_address,
    input  logic [N_PORTS-1:0]                req_read,
    input  logic [N_PORTS-1:0]                req_write,
    input  logic [N_PORTS-1:0][DATA_W-1:0]    req_writedata,
    input  logic [N_PORTS-1:0][DATA_W/8-1:0]  req_byteenable,
    output logic [N_PORTS-1:0][DATA_W-1:0]    req_readdata,
    output logic [N_PORTS-1:0]                req_stall,
    output logic [ADDR_W-1:0]                 bus_address,
    output logic                              bus_read,
    output logic                              bus_write,
    output logic [DATA_W-1:0]                 bus_writedata,
    output logic [DATA_W/8-1:0]               bus_byteenable,
    input  logic [DATA_W-1:0]                 bus_readdata,
    input  logic                              bus_waitrequest,
    output logic                              busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = idx_width(N_PORTS);

    bridge_state_t        state, state_next;
    logic [N_PORTS-1:0]   req_any, grant;
    logic [IDX_W-1:0]     grant_idx, grant_q;
    logic                 accept, complete;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [BE_W-1:0]      sel_be;
    logic                 sel_wr;

    assign req_any = req_read | req_write;

    mips_bus_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_arbiter (
`ifdef MIPS_BRIDGE_ROUND_ROBIN_EN
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
`endif
        .req       (req_any),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            ST_IDLE: if (|req_any) begin
                accept     = 1'b1;
                state_next = ST_BUS;
            end
            ST_BUS: if (!bus_waitrequest) begin
                complete   = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Write wins when a port raises both strobes.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                sel_addr  = req_address[i];
                sel_wdata = req_writedata[i];
                sel_be    = req_byteenable[i];
                sel_wr    = req_write[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_address    <= '0;
            bus_writedata  <= '0;
            bus_byteenable <= '0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            grant_q        <= '0;
        end else if (accept) begin
            bus_address    <= sel_addr;
            bus_writedata  <= sel_wdata;
            bus_byteenable <= sel_be;
            bus_read       <= !sel_wr;
            bus_write      <= sel_wr;
            grant_q        <= grant_idx;
        end else if (complete) begin
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_readdata <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (complete && (grant_q == IDX_W'(i))) begin
                    req_readdata[i] <= bus_write ? '0 : bus_readdata;
                end
            end
        end
    end

    always_comb begin
        req_stall = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            req_stall[i] = req_any[i] & ~((state == ST_DONE) && (grant_q == IDX_W'(i)));
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mips_harvard_bus_bridge.sv
// tb/tb_mips_harvard_bus_bridge.sv - randomized and directed bench with a transaction-level reference model
module tb_mips_harvard_bus_bridge;

    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0][31:0]   req_address;
    logic [N-1:0]         req_read, req_write;
    logic [N-1:0][31:0]   req_writedata;
    logic [N-1:0][3:0]    req_byteenable;
    logic [N-1:0][31:0]   req_readdata;
    logic [N-1:0]         req_stall;
    logic [31:0]          bus_address, bus_writedata, bus_readdata;
    logic                 bus_read, bus_write, bus_waitrequest, busy;
    logic [3:0]           bus_byteenable;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_harvard_bus_bridge dut (
        .clk             (clk),
        .reset           (reset),
        .req_address     (req_address),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_writedata   (req_writedata),
        .req_byteenable  (req_byteenable),
        .req_readdata    (req_readdata),
        .req_stall       (req_stall),
        .bus_address     (bus_address),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_writedata   (bus_writedata),
        .bus_byteenable  (bus_byteenable),
        .bus_readdata    (bus_readdata),
        .bus_waitrequest (bus_waitrequest),
        .busy            (busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: phase 0 waiting, 1 bus transfer outstanding, 2 completion reported
    int           m_phase, m_g, m_last;
    logic [31:0]  m_addr, m_wdata;
    logic [3:0]   m_be;
    logic         m_wr;
    logic [31:0]  m_rdata [N];

    function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef MIPS_BRIDGE_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (r[k]) return k;
        end
`endif
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_last  <= 0;
            m_g     <= 0;
            for (int i = 0; i < N; i++) m_rdata[i] <= '0;
        end else begin
            case (m_phase)
                0: if (|(req_read | req_write)) begin
                    m_g     <= pick(req_read | req_write, m_last);
                    m_last  <= pick(req_read | req_write, m_last);
                    m_addr  <= req_address[pick(req_read | req_write, m_last)];
                    m_wdata <= req_writedata[pick(req_read | req_write, m_last)];
                    m_be    <= req_byteenable[pick(req_read | req_write, m_last)];
                    m_wr    <= req_write[pick(req_read | req_write, m_last)];
                    m_phase <= 1;
                end
                1: if (!bus_waitrequest) begin
                    m_rdata[m_g] <= m_wr ? 32'h0 : bus_readdata;
                    m_phase      <= 2;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    logic [N-1:0] exp_stall;
    logic [N-1:0] completed;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                exp_stall[i] = (req_read[i] | req_write[i]) && !(m_phase == 2 && m_g == i);
                completed[i] = (req_read[i] | req_write[i]) && !req_stall[i];
            end
            check("stall", req_stall, exp_stall);
            check("busy", busy, m_phase != 0);
            check("bus_read", bus_read, (m_phase == 1) && !m_wr);
            check("bus_write", bus_write, (m_phase == 1) && m_wr);
            if (m_phase == 1) begin
                check("bus_address", bus_address, m_addr);
                check("bus_writedata", bus_writedata, m_wdata);
                check("bus_byteenable", bus_byteenable, m_be);
            end
            for (int i = 0; i < N; i++) check("readdata", req_readdata[i], m_rdata[i]);
        end else begin
            completed = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        req_read  = '0;
        req_write = '0;
        bus_waitrequest = 1'b0;
        for (int k = 0; k < 20 && busy; k++) step();
        check("idle_reached", busy, 1'b0);
        step();
    endtask

    logic [N-1:0] active;
    int           order [3];
    int           got;
    int           exp_order [3];
    int           kind;
    logic         rearmed;

    initial begin
        reset = 1'b0;
        req_address = '0; req_read = '0; req_write = '0;
        req_writedata = '0; req_byteenable = '0;
        bus_readdata = '0; bus_waitrequest = 1'b0;
        active = '0;
        repeat (2) step();
        check("rst_bus_read", bus_read, 1'b0);
        check("rst_bus_write", bus_write, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bus_address", bus_address, 32'h0);
        check("rst_readdata", req_readdata, 64'h0);
        reset = 1'b1;

        // Simultaneous requests straight after reset (pointer at 0)
        req_read = 2'b11;
        req_address[0] = 32'h200;
        req_address[1] = 32'h300;
        got = 0;
        rearmed = 1'b0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_read[i] && !req_stall[i] && got < 3) begin
                    order[got] = i;
                    got++;
                end
            end
            step();
            for (int i = 0; i < N; i++) if (completed[i]) req_read[i] = 1'b0;
            if (got == 2 && !rearmed) begin
                req_read = 2'b11;
                rearmed  = 1'b1;
            end
        end
`ifdef MIPS_BRIDGE_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1};
`else
        exp_order = '{0, 1, 0};
`endif
        check("order_count", got, 3);
        for (int k = 0; k < 3; k++) check("grant_order", order[k], exp_order[k]);
        go_idle();

        // Port 1 read, no wait states
        req_read[1] = 1'b1;
        req_address[1] = 32'h0000_0040;
        bus_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("r1_stall_idle", req_stall[1], 1'b1);
        @(negedge clk);
        check("r1_stall_bus", req_stall[1], 1'b1);
        check("r1_bus_read", bus_read, 1'b1);
        check("r1_bus_address", bus_address, 32'h40);
        @(negedge clk);
        check("r1_stall_done", req_stall[1], 1'b0);
        check("r1_readdata", req_readdata[1], 32'hDEAD_BEEF);
        go_idle();

        // Port 0 write with four wait-state cycles
        req_write[0] = 1'b1;
        req_address[0] = 32'h100;
        req_writedata[0] = 32'h1234_5678;
        req_byteenable[0] = 4'h3;
        bus_waitrequest = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k >= 5) bus_waitrequest = 1'b0;
            @(negedge clk);
            if (k >= 1 && k <= 5) begin
                check("w0_bus_write", bus_write, 1'b1);
                check("w0_bus_address", bus_address, 32'h100);
                check("w0_bus_writedata", bus_writedata, 32'h1234_5678);
                check("w0_bus_byteenable", bus_byteenable, 4'h3);
            end
            if (k <= 5) check("w0_stall", req_stall[0], 1'b1);
            if (k == 6) begin
                check("w0_stall_done", req_stall[0], 1'b0);
                check("w0_bus_write_done", bus_write, 1'b0);
                check("w0_readdata", req_readdata[0], 32'h0);
            end
            step();
        end
        go_idle();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!active[i] || completed[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        active[i] = 1'b1;
                        kind = $urandom_range(0, 9);
                        req_read[i]  = (kind < 5) || (kind == 9);
                        req_write[i] = (kind >= 5);
                        req_address[i] = $urandom;
                        req_writedata[i] = $urandom;
                        req_byteenable[i] = 4'($urandom_range(0, 15));
                    end else begin
                        active[i] = 1'b0;
                        req_read[i] = 1'b0;
                        req_write[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    active[i] = 1'b0;
                    req_read[i] = 1'b0;
                    req_write[i] = 1'b0;
                end
            end
            bus_waitrequest = ($urandom_range(0, 2) == 0);
            bus_readdata = $urandom;
            step();
        end
        active = '0;
        go_idle();

        // Port 0 read to load a known value, then read+write together
        req_read[0] = 1'b1;
        bus_readdata = 32'hA5A5_A5A5;
        repeat (3) @(negedge clk);
        check("rd0_readdata", req_readdata[0], 32'hA5A5_A5A5);
        go_idle();
        req_read[0] = 1'b1;
        req_write[0] = 1'b1;
        bus_readdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        check("rw0_bus_write", bus_write, 1'b1);
        check("rw0_bus_read", bus_read, 1'b0);
        @(negedge clk);
        check("rw0_stall", req_stall[0], 1'b0);
        check("rw0_readdata", req_readdata[0], 32'h0);
        go_idle();

        // Reset pulse while a transfer is stalled on the bus
        req_read[0] = 1'b1;
        req_address[0] = 32'h80;
        bus_waitrequest = 1'b1;
        step();
        step();
        check("rst_mid_bus_read_pre", bus_read, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_bus_read", bus_read, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_address", bus_address, 32'h0);
        req_read = '0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        bus_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_after_busy", busy, 1'b0);
            check("rst_after_readdata", req_readdata[0], 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
